// File: rtl/parallel_subtractor_reg.sv
// Registered ripple-borrow subtractor (diff = a - b, bout = a < b) built from 1-bit full subtractors.
// Latency: 1 clk from in_valid to out_valid. Backpressure: none, one result per cycle.
// Idle cycles (in_valid=0) hold diff/bout and drop out_valid.

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);
endmodule

module parallel_subtractor_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid
);
  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] d;

  assign br[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_subtractor u_fs (
      .a   (a[i]),
      .b   (b[i]),
      .bin (br[i]),
      .d   (d[i]),
      .bo  (br[i+1])
    );
  end

  // Capture gated by in_valid so undriven operands during idle cycles never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff <= d;
        bout <= br[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_parallel_subtractor_reg.sv
// Directed-vector bench for parallel_subtractor_reg at WIDTH=4.
module tb_parallel_subtractor_reg;
  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic [3:0] diff;
  logic       bout;
  logic       out_valid;

  int vectors;
  int miscompares;

  logic [3:0] row_a [4];
  logic [3:0] row_b [4];
  logic [5:0] row_exp [4];

  parallel_subtractor_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .diff      (diff),
    .bout      (bout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; a = 4'd9; b = 4'd5; in_valid = 1'b1;
    #3;
    vectors++;
    if ({out_valid, bout, diff} !== 6'b0_0_0000) begin
      miscompares++;
      $display("FAIL reset_async: got ov=%b bout=%b diff=%b, want 0 0 0000", out_valid, bout, diff);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, bout, diff} !== 6'b0_0_0000) begin
      miscompares++;
      $display("FAIL reset_held: got ov=%b bout=%b diff=%b, want 0 0 0000", out_valid, bout, diff);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, bout, diff} !== 6'b0_0_0000) begin
      miscompares++;
      $display("FAIL reset_release_idle: got ov=%b bout=%b diff=%b, want 0 0 0000", out_valid, bout, diff);
    end
  endtask

  task automatic test_rows();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = row_a[i]; b = row_b[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, bout, diff} !== row_exp[i]) begin
        miscompares++;
        $display("FAIL row%0d a=%0d b=%0d: got ov=%b bout=%b diff=%b, want %b", i + 1,
                 row_a[i], row_b[i], out_valid, bout, diff, row_exp[i]);
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = row_a[0]; b = row_b[0]; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, bout, diff} !== row_exp[i]) begin
        miscompares++;
        $display("FAIL b2b_row%0d: got ov=%b bout=%b diff=%b, want %b", i + 1,
                 out_valid, bout, diff, row_exp[i]);
      end
      @(negedge clk);
      if (i < 3) begin
        a = row_a[i+1]; b = row_b[i+1];
      end else begin
        in_valid = 1'b0; a = 4'd0; b = 4'd0;
      end
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, bout, diff} !== 6'b0_1_1100) begin
      miscompares++;
      $display("FAIL hold_after_b2b: got ov=%b bout=%b diff=%b, want 0 1 1100", out_valid, bout, diff);
    end
  endtask

  task automatic test_x_inputs();
    @(negedge clk);
    a = 4'bxxxx; b = 4'bzzzz; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, bout, diff} !== 6'b0_1_1100) begin
      miscompares++;
      $display("FAIL x_while_idle: got ov=%b bout=%b diff=%b, want 0 1 1100", out_valid, bout, diff);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    a = 4'd3; b = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 4'd9; b = 4'd5;
    vectors++;
    if ({out_valid, bout, diff} !== 6'b1_1_1100) begin
      miscompares++;
      $display("FAIL pre_reset_row4: got ov=%b bout=%b diff=%b, want 1 1 1100", out_valid, bout, diff);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, bout, diff} !== 6'b0_0_0000) begin
      miscompares++;
      $display("FAIL mid_reset_async: got ov=%b bout=%b diff=%b, want 0 0 0000", out_valid, bout, diff);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, bout, diff} !== 6'b0_0_0000) begin
      miscompares++;
      $display("FAIL mid_reset_discard: got ov=%b bout=%b diff=%b, want 0 0 0000", out_valid, bout, diff);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_sweep();
    logic [3:0] exp_d;
    logic       exp_b;
    int         dd;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        @(negedge clk);
        a = ai[3:0]; b = bi[3:0]; in_valid = 1'b1;
        dd    = ai - bi;
        exp_d = dd[3:0];
        exp_b = (ai < bi);
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, bout, diff} !== {1'b1, exp_b, exp_d}) begin
          miscompares++;
          $display("FAIL sweep a=%0d b=%0d: got ov=%b bout=%b diff=%0d, want 1 %b %0d",
                   ai, bi, out_valid, bout, diff, exp_b, exp_d);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    row_a[0] = 4'd9;  row_b[0] = 4'd5; row_exp[0] = 6'b1_0_0100;
    row_a[1] = 4'd7;  row_b[1] = 4'd3; row_exp[1] = 6'b1_0_0100;
    row_a[2] = 4'd15; row_b[2] = 4'd9; row_exp[2] = 6'b1_0_0110;
    row_a[3] = 4'd3;  row_b[3] = 4'd7; row_exp[3] = 6'b1_1_1100;

    test_reset();
    test_rows();
    test_back_to_back();
    test_x_inputs();
    test_mid_reset();
    test_sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
